// File: rtl/insert_y.sv
// Rebuilds the N-digit write-path word by serially re-inserting Y digits into an M-digit payload.
// Each Y digit is the previous output digit plus one, so it never repeats its lower neighbour.
module insert_y #(
  parameter int N = 100,
  parameter int M = 84,
  parameter logic [N-1:0] Y_MASK =
    N'((100'hF << 96) | (100'h7 << 62) | (100'h7 << 14) | 100'h3F)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] word_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] word_out,
  output logic           busy
);

  localparam int POS_W = $clog2(N);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N - 1);

  if ($countones(Y_MASK) != N - M) begin : g_bad_mask
    $error("insert_y: popcount of Y_MASK must equal N-M");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [2*M-1:0]   sr;
  logic [POS_W-1:0] pos;
  logic [1:0]       prev;
  logic [1:0]       d;
  logic [2*N-1:0]   word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (pos == LAST_POS) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Y positions bump the previous digit; payload positions pop the next input digit.
  always_comb begin
    d = sr[1:0];
    if (Y_MASK[pos]) d = prev + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      pos    <= '0;
      prev   <= 2'b00;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr     <= word_in;
            pos    <= '0;
            prev   <= 2'b00;
            word_q <= '0;
          end
        end
        RUN: begin
          word_q[{pos, 1'b0} +: 2] <= d;
          prev <= d;
          pos  <= pos + 1'b1;
          if (!Y_MASK[pos]) sr <= sr >> 2;
        end
        default: ;
      endcase
    end
  end

  assign word_out = word_q;

endmodule

// File: tb/tb_insert_y.sv
// Self-checking bench for insert_y: directed vector table, backpressure, mid-word reset,
// back-to-back throughput and randomised round-trip checks.
module tb_insert_y;
  localparam int N  = 100;
  localparam int M  = 84;
  localparam int NY = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*M-1:0] word_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] word_out;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  insert_y dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .word_in(word_in),
    .out_valid(out_valid), .out_ready(out_ready), .word_out(word_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [0:NY-1][1:0] ydig_t;
  typedef struct {
    string          name;
    logic [2*M-1:0] word;
    ydig_t          exp_y;
  } vec_t;

  vec_t vecs[4];

  function automatic bit is_y(int i);
    return (i <= 5) || (i >= 14 && i <= 16) || (i >= 62 && i <= 64) || (i >= 96);
  endfunction

  function automatic logic [2*M-1:0] strip_y(logic [2*N-1:0] w);
    logic [2*M-1:0] s = '0;
    int j = 0;
    for (int i = 0; i < N; i++) begin
      if (!is_y(i)) begin
        s[2*j +: 2] = w[2*i +: 2];
        j++;
      end
    end
    return s;
  endfunction

  function automatic ydig_t get_y(logic [2*N-1:0] w);
    ydig_t g = '0;
    int k = 0;
    for (int i = 0; i < N; i++) begin
      if (is_y(i)) begin
        g[k] = w[2*i +: 2];
        k++;
      end
    end
    return g;
  endfunction

  // Counts Y digits that equal their lower neighbour, plus a wrong digit 0.
  function automatic int run_violations(logic [2*N-1:0] w);
    int n = 0;
    if (w[1:0] != 2'b01) n++;
    for (int i = 1; i < N; i++)
      if (is_y(i) && w[2*i +: 2] == w[2*i-2 +: 2]) n++;
    return n;
  endfunction

  function automatic logic [2*M-1:0] rand_word();
    logic [2*M-1:0] w;
    for (int j = 0; j < M; j++) w[2*j +: 2] = 2'($urandom);
    return w;
  endfunction

  task automatic check_output(input string name, input logic [2*N-1:0] act,
                              input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (%h) want %0d (%h)", name, act, act, exp, exp);
    end
  endtask

  // Sends one word, waits (bounded) for the result, then completes the output handshake.
  // lat counts rising edges from the accept edge (inclusive) to the edge raising out_valid.
  task automatic apply_stimulus(input logic [2*M-1:0] w, output logic [2*N-1:0] res,
                                output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    word_in  = w;
    check_bit("in_ready before accept", in_ready, 1'b1);
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
    end
    res = word_out;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_bit("in_ready after out handshake", in_ready, 1'b1);
    check_bit("out_valid after out handshake", out_valid, 1'b0);
  endtask

  task automatic check_word(input string name, input logic [2*M-1:0] w,
                            input logic [2*N-1:0] res);
    check_output({name, " round trip"}, (2*N)'(strip_y(res)), (2*N)'(w));
    check_int({name, " y neighbour"}, run_violations(res), 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2*N-1:0] res;
    logic [2*N-1:0] snap;
    logic [2*M-1:0] w;
    logic [2*M-1:0] b2b[3];
    int lat;
    int acc[3];
    int t;
    bit got;
    bit seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; word_in = '0;

    // Y digits are listed at positions 0-5, 14-16, 62-64, 96-99 in that order.
    vecs[0] = '{"zeros", '0,
      {2'd1,2'd2,2'd3,2'd0,2'd1,2'd2, 2'd1,2'd2,2'd3, 2'd1,2'd2,2'd3, 2'd1,2'd2,2'd3,2'd0}};
    vecs[1] = '{"j mod 4", {21{8'hE4}},
      {2'd1,2'd2,2'd3,2'd0,2'd1,2'd2, 2'd0,2'd1,2'd2, 2'd1,2'd2,2'd3, 2'd0,2'd1,2'd2,2'd3}};
    vecs[2] = '{"all threes", '1,
      {2'd1,2'd2,2'd3,2'd0,2'd1,2'd2, 2'd0,2'd1,2'd2, 2'd0,2'd1,2'd2, 2'd0,2'd1,2'd2,2'd3}};
    vecs[3] = '{"all ones", {M{2'b01}},
      {2'd1,2'd2,2'd3,2'd0,2'd1,2'd2, 2'd2,2'd3,2'd0, 2'd2,2'd3,2'd0, 2'd2,2'd3,2'd0,2'd1}};

    // in_valid during reset must be ignored.
    in_valid = 1'b1;
    word_in  = {M{2'b10}};
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_output("reset word_out", word_out, '0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].word, res, lat);
      check_int({vecs[v].name, " latency"}, lat, N + 1);
      check_int({vecs[v].name, " y digits"}, int'(get_y(res)), int'(vecs[v].exp_y));
      check_word(vecs[v].name, vecs[v].word, res);
    end

    // Backpressure: hold DONE for 20 cycles while offering a new word.
    apply_stimulus(vecs[1].word, res, lat);
    @(negedge clk);
    in_valid = 1'b1;
    word_in  = vecs[1].word;
    @(posedge clk);
    #1 in_valid = 1'b1;
    word_in = vecs[2].word;
    t = 0;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_bit("hold reached done", out_valid, 1'b1);
    snap = word_out;
    check_word("hold", vecs[1].word, snap);
    repeat (20) begin
      @(negedge clk);
      check_output("hold word_out stable", word_out, snap);
      check_bit("hold out_valid", out_valid, 1'b1);
      check_bit("hold in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check_bit("hold in_ready after release", in_ready, 1'b1);

    // Asynchronous reset while pos is 50.
    @(negedge clk);
    in_valid = 1'b1;
    word_in  = vecs[2].word;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_bit("midrun reset in_ready", in_ready, 1'b1);
    check_bit("midrun reset out_valid", out_valid, 1'b0);
    check_bit("midrun reset busy", busy, 1'b0);
    check_output("midrun reset word_out", word_out, '0);
    @(negedge clk) rst = 1'b0;
    apply_stimulus(vecs[0].word, res, lat);
    check_int("post reset latency", lat, N + 1);
    check_int("post reset y digits", int'(get_y(res)), int'(vecs[0].exp_y));
    check_word("post reset", vecs[0].word, res);

    // Back-to-back words with in_valid and out_ready held high.
    for (int k = 0; k < 3; k++) b2b[k] = rand_word();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      check_bit("b2b in_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      word_in  = b2b[k];
      acc[k]   = cyc;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 300) begin
        @(negedge clk);
        t++;
      end
      check_bit("b2b out_valid", out_valid, 1'b1);
      check_word("b2b", b2b[k], word_out);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_int("b2b period 0-1", acc[1] - acc[0], N + 2);
    check_int("b2b period 1-2", acc[2] - acc[1], N + 2);

    // Random words with random out_ready.
    for (int k = 0; k < 150; k++) begin
      w = rand_word();
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      in_valid = 1'b1;
      word_in  = w;
      @(negedge clk);
      in_valid = 1'b0;
      got  = 1'b0;
      seen = 1'b0;
      t = 0;
      while (!got && t < 400) begin
        t++;
        if (busy) check_bit("rand in_ready while busy", in_ready, 1'b0);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid) begin
          if (!seen) check_word("rand", w, word_out);
          seen = 1'b1;
          if (out_ready) got = 1'b1;
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
      check_bit("rand word completed", got, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
